// File: rtl/ising_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ising_run_ctrl
// Description : Run sequencer for an N-oscillator Ising array. Owns the
//               coupling-weight register file, drives the array's weight
//               buses and active-low reset, and runs one solve per start:
//               RESET -> RUN (settle) -> SAMPLE (phase vote vs osc 0) ->
//               REPORT (valid/ready spin vector).
//               Optional readback port enabled by ISING_CTRL_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ising_run_ctrl #(
  parameter int N             = 3,
  parameter int WBITS         = 3,
  parameter int ZERO_W        = 2,
  parameter int RESET_CYCLES  = 100,
  parameter int RUN_CYCLES    = 1000,
  parameter int SAMPLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(N*N)-1:0]    cfg_addr,
  input  logic [WBITS-1:0]          cfg_wdata,
`ifdef ISING_CTRL_READBACK_EN
  input  logic                      cfg_re,
  output logic [WBITS-1:0]          cfg_rdata,
  output logic                      cfg_rvalid,
`endif
  input  logic                      start,
  output logic                      busy,
  output logic                      osc_rstn,
  output logic [N*N*WBITS-1:0]      weights_out,
  input  logic [N-1:0]              osc_out,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [N-1:0]              result_spins
);

  localparam int                AW          = $clog2(N*N);
  localparam int                NE          = N * N;
  localparam int                MW          = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [WBITS-1:0]  ZW          = WBITS'(ZERO_W);
  localparam logic [MW-1:0]     HALF        = MW'(SAMPLE_CYCLES / 2);
  localparam logic [CNT_W-1:0]  RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MW-1:0]           match_q [1:N-1];
  logic [MW-1:0]           match_d [1:N-1];
  logic [N-1:0]            spins_q, spins_d;
  logic [N-1:0]            osc_meta_q, osc_meta_d;
  logic [N-1:0]            osc_sync_q, osc_sync_d;
  logic [NE*WBITS-1:0]     weights_q, weights_d;
  logic                    wr_en;

  // Two-stage synchronizer for the free-running oscillator outputs
  always_comb begin
    osc_meta_d = osc_out;
    osc_sync_d = osc_meta_q;
  end

  // Weight file: writes land only while idle, so a run sees frozen weights
  always_comb begin
    wr_en     = cfg_we && (state_q == ST_IDLE);
    weights_d = weights_q;
    for (int k = 0; k < NE; k++) begin
      if (wr_en && (cfg_addr == AW'(k))) begin
        weights_d[k*WBITS +: WBITS] = cfg_wdata;
      end
    end
  end

  // Sequencer next-state, phase-match counting and spin decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    spins_d = spins_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          for (int i = 1; i < N; i++) match_d[i] = '0;
        end
      end
      ST_RESET: begin
        if (cnt_q == RESET_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        for (int i = 1; i < N; i++) begin
          match_d[i] = match_q[i] + MW'(osc_sync_q[i] == osc_sync_q[0]);
        end
        if (cnt_q == SAMPLE_LAST) begin
          // Decide from the counts including this final sample; ties give 0
          state_d    = ST_REPORT;
          cnt_d      = '0;
          spins_d[0] = 1'b1;
          for (int i = 1; i < N; i++) spins_d[i] = (match_d[i] > HALF);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, synchronizer and weight registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      spins_q    <= '0;
      osc_meta_q <= '0;
      osc_sync_q <= '0;
      weights_q  <= {NE{ZW}};
      for (int i = 1; i < N; i++) match_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spins_q    <= spins_d;
      osc_meta_q <= osc_meta_d;
      osc_sync_q <= osc_sync_d;
      weights_q  <= weights_d;
      for (int i = 1; i < N; i++) match_q[i] <= match_d[i];
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign osc_rstn     = (state_q == ST_RUN) || (state_q == ST_SAMPLE);
  assign result_valid = (state_q == ST_REPORT);
  assign result_spins = spins_q;
  assign weights_out  = weights_q;

`ifdef ISING_CTRL_READBACK_EN
  logic [WBITS-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  // Readback mux; reads the pre-write value when a write hits the same cycle
  always_comb begin
    rvalid_d = cfg_re;
    rdata_d  = '0;
    if (cfg_re) begin
      for (int k = 0; k < NE; k++) begin
        if (cfg_addr == AW'(k)) rdata_d = weights_q[k*WBITS +: WBITS];
      end
    end
  end

  // Readback response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ising_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ising_run_ctrl
// Description : Self-checking bench for ising_run_ctrl with short run timing.
//               Exercises ISING_CTRL_READBACK_EN ports when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ising_run_ctrl;

  localparam int N     = 3;
  localparam int WBITS = 3;
  localparam int ZW    = 2;
  localparam int RC    = 4;
  localparam int UC    = 8;
  localparam int SC    = 4;
  localparam int NE    = N * N;
  localparam int AW    = $clog2(NE);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [WBITS-1:0]      cfg_wdata;
  logic                  start;
  logic                  busy;
  logic                  osc_rstn;
  logic [NE*WBITS-1:0]   weights_out;
  logic [N-1:0]          osc_out;
  logic                  result_valid;
  logic                  result_ready;
  logic [N-1:0]          result_spins;
`ifdef ISING_CTRL_READBACK_EN
  logic                  cfg_re;
  logic [WBITS-1:0]      cfg_rdata;
  logic                  cfg_rvalid;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WBITS-1:0] wm   [NE];
  logic [N-1:0]     hist [0:63];

  ising_run_ctrl #(
    .N(N), .WBITS(WBITS), .ZERO_W(ZW), .RESET_CYCLES(RC),
    .RUN_CYCLES(UC), .SAMPLE_CYCLES(SC), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
`ifdef ISING_CTRL_READBACK_EN
    .cfg_re(cfg_re), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
`endif
    .start(start), .busy(busy), .osc_rstn(osc_rstn),
    .weights_out(weights_out), .osc_out(osc_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_spins(result_spins)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NE*WBITS-1:0] model_w();
    logic [NE*WBITS-1:0] v;
    for (int k = 0; k < NE; k++) v[k*WBITS +: WBITS] = wm[k];
    return v;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < NE; k++) wm[k] = WBITS'(ZW);
  endtask

  // Majority vote over the window: sync lags the pins by two cycles, so the
  // sample cycles RC+UC..RC+UC+SC-1 see what was driven two cycles earlier.
  function automatic logic [N-1:0] model_spins();
    logic [N-1:0] s;
    int m;
    s    = '0;
    s[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      m = 0;
      for (int c = RC + UC - 2; c < RC + UC + SC - 2; c++) begin
        if (hist[c][i] == hist[c][0]) m++;
      end
      s[i] = (m > SC / 2);
    end
    return s;
  endfunction

  // One solve. pat: 0 = decode pattern, 1 = tie on osc 1, 2 = random.
  task automatic run_one(input int pat, input int hold, input int rst_at);
    logic [N-1:0] o;
    logic [N-1:0] es;
    start     = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = AW'($urandom_range(6, 8));
    cfg_wdata = WBITS'($urandom);
    wm[cfg_addr] = cfg_wdata;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    chk("start_write_accepted", weights_out, model_w());
    for (int c = 0; c < RC + UC + SC; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_model();
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_rstn", osc_rstn, 0);
        chk("midrst_weights", weights_out, model_w());
`ifdef ISING_CTRL_READBACK_EN
        cfg_re   = 1'b1;
        cfg_addr = AW'(5);
        tick();
        cfg_re = 1'b0;
        chk("midrst_rb_valid", cfg_rvalid, 1);
        chk("midrst_rb_data", cfg_rdata, 3'b010);
`endif
        for (int k = 0; k < 24; k++) begin
          tick();
          chk("midrst_no_valid", result_valid, 0);
        end
        return;
      end
      chk("run_busy", busy, 1);
      chk("run_rstn", osc_rstn, (c >= RC));
      chk("run_valid_low", result_valid, 0);
      chk("run_weights", weights_out, model_w());
      if (pat == 0 && c == RC + 3) begin
        chk("run_entry5", weights_out[17:15], 3'b100);
        chk("run_entry1_kept", weights_out[5:3], 3'b010);
      end
      case (pat)
        0:       o = {~c[0], c[0], c[0]};
        1:       o = {1'($urandom), ((c == RC + UC - 2) || (c == RC + UC - 1)) ? 1'b0 : 1'b1, 1'b0};
        default: o = N'($urandom);
      endcase
      hist[c]   = o;
      osc_out   = o;
      cfg_we    = (c == RC + 2);
      cfg_addr  = AW'(1);
      cfg_wdata = ~wm[1];
      start     = (c == RC + 3);
      tick();
    end
    es = model_spins();
    chk("latency_valid", result_valid, 1);
    chk("report_rstn", osc_rstn, 0);
    chk("report_spins", result_spins, es);
    if (pat == 0) chk("decode_011", result_spins, 3'b011);
    if (pat == 1) chk("tie_spin1", result_spins[1], 0);
    for (int h = 0; h < hold; h++) begin
      result_ready = 1'b0;
      osc_out      = N'($urandom);
      tick();
      chk("hold_valid", result_valid, 1);
      chk("hold_spins", result_spins, es);
      chk("hold_busy", busy, 1);
    end
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    chk("done_valid", result_valid, 0);
    chk("done_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_second_run", busy, 0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    start        = 1'b0;
    osc_out      = '0;
    result_ready = 1'b0;
`ifdef ISING_CTRL_READBACK_EN
    cfg_re       = 1'b0;
`endif
    reset_model();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_weights", weights_out, {NE{3'b010}});
    chk("rst_rstn", osc_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_spins", result_spins, 0);
`ifdef ISING_CTRL_READBACK_EN
    chk("rst_rvalid", cfg_rvalid, 0);
    chk("rst_rdata", cfg_rdata, 0);
`endif

    // Entry 5 write in IDLE
    cfg_we    = 1'b1;
    cfg_addr  = AW'(5);
    cfg_wdata = 3'b100;
    wm[5]     = 3'b100;
    tick();
    cfg_we = 1'b0;
    chk("wr5_bits", weights_out[17:15], 3'b100);
    chk("wr5_all", weights_out, model_w());

    // Out-of-range addresses are ignored
    for (int a = NE; a < (1 << AW); a++) begin
      cfg_we    = 1'b1;
      cfg_addr  = AW'(a);
      cfg_wdata = WBITS'($urandom);
      tick();
      cfg_we = 1'b0;
      chk("oor_write", weights_out, model_w());
    end

`ifdef ISING_CTRL_READBACK_EN
    // Same-cycle read and write returns the old value
    cfg_re    = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = AW'(7);
    cfg_wdata = 3'b001;
    tick();
    chk("rb_old_valid", cfg_rvalid, 1);
    chk("rb_old_data", cfg_rdata, wm[7]);
    wm[7]  = 3'b001;
    cfg_we = 1'b0;
    tick();
    chk("rb_new_data", cfg_rdata, 3'b001);
    cfg_addr = AW'(12);
    tick();
    cfg_re = 1'b0;
    chk("rb_oor_data", cfg_rdata, 0);
    tick();
    chk("rb_idle_valid", cfg_rvalid, 0);
`endif

    run_one(0, 5, -1);
    run_one(1, 2, -1);

    // Randomized IDLE writes, including out-of-range addresses
    for (int k = 0; k < 8; k++) begin
      cfg_we    = 1'b1;
      cfg_addr  = AW'($urandom);
      cfg_wdata = WBITS'($urandom);
      if (int'(cfg_addr) < NE) wm[cfg_addr] = cfg_wdata;
      tick();
      cfg_we = 1'b0;
      chk("rand_write", weights_out, model_w());
    end

    for (int r = 0; r < 5; r++) run_one(2, $urandom_range(0, 3), -1);

    // Reset in the middle of SAMPLE
    run_one(2, 0, RC + UC + 1);
    run_one(2, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
